// File: rtl/niu_sii_inb_pkg.sv
// Shared types for the NIU->SII inbound checker: FSM states and err_sticky bit positions.
// Types and constants only; no timing or flow-control behaviour.
package niu_sii_inb_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  localparam int ERR_PAR        = 0;
  localparam int ERR_HDR_IN_PAY = 1;
  localparam int ERR_DREQ16     = 2;
  localparam int ERR_OQ_OVF     = 3;
  localparam int ERR_OQ_UNF     = 4;
  localparam int ERR_W          = 5;

endpackage

// File: rtl/niu_sii_par_calc.sv
// Expected parity for the NIU->SII bus: one XOR bit per 16-bit data slice.
// Purely combinational (zero latency); no flow control.
module niu_sii_par_calc #(
  parameter int DATA_W = 128
) (
  input  logic [DATA_W-1:0]    data_i,
  output logic [DATA_W/16-1:0] par_o
);

  for (genvar g = 0; g < DATA_W/16; g++) begin : g_slice
    assign par_o[g] = ^data_i[16*g +: 16];
  end

endmodule

// File: rtl/niu_sii_inb_chk.sv
// NIU->SII inbound protocol checker: counts reads/writes/bypass headers, tracks ordered-queue occupancy,
// flags protocol errors (parity only with NIU_SII_INB_PARCHK_EN). Outputs registered, 1 cycle; passive, no backpressure.
module niu_sii_inb_chk
  import niu_sii_inb_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int PAY_BEATS = 4,
  parameter int OQ_DEPTH  = 16,
  parameter int CNT_W     = 32
) (
  input  logic                          iol2clk,
  input  logic                          rst_l,
  input  logic                          enable,
  input  logic                          clr,
  input  logic                          niu_sii_hdr_vld,
  input  logic                          niu_sii_reqbypass,
  input  logic                          niu_sii_datareq,
  input  logic                          niu_sii_datareq16,
  input  logic [DATA_W-1:0]             niu_sii_data,
  input  logic [DATA_W/16-1:0]          niu_sii_parity,
  input  logic                          sii_niu_oqdq,
  output logic [CNT_W-1:0]              rd_cnt,
  output logic [CNT_W-1:0]              wr_cnt,
  output logic [CNT_W-1:0]              byp_cnt,
  output logic [$clog2(OQ_DEPTH+1)-1:0] oq_occ,
  output logic [ERR_W-1:0]              err_sticky,
  output logic                          err_pulse
);

  localparam int BEAT_W = (PAY_BEATS > 1) ? $clog2(PAY_BEATS) : 1;
  localparam int OCC_W  = $clog2(OQ_DEPTH + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PAY_BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [OCC_W-1:0]  OQ_FULL   = OCC_W'(OQ_DEPTH);
  localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   byp_cnt_q, byp_cnt_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [ERR_W-1:0]   err_q, err_d, err_det;
  logic               pulse_q, pulse_d;
  logic               hdr_acc, oq_inc, oq_dec, par_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

`ifdef NIU_SII_INB_PARCHK_EN
  logic [DATA_W/16-1:0] par_exp;

  niu_sii_par_calc #(.DATA_W(DATA_W)) u_par_calc (
    .data_i (niu_sii_data),
    .par_o  (par_exp)
  );

  // Every header cycle (accepted or not) and every payload beat carries checked parity.
  assign par_err = (niu_sii_hdr_vld || (state_q == ST_PAYLOAD)) && (par_exp != niu_sii_parity);
`else
  logic unused_bus;
  assign unused_bus = ^{niu_sii_data, niu_sii_parity};
  assign par_err    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    byp_cnt_d = byp_cnt_q;
    occ_d     = occ_q;
    err_det   = '0;
    hdr_acc   = 1'b0;
    oq_inc    = 1'b0;
    oq_dec    = 1'b0;

    if (enable) begin
      if (state_q == ST_IDLE) begin
        if (niu_sii_hdr_vld) begin
          if (niu_sii_datareq16) begin
            err_det[ERR_DREQ16] = 1'b1;
          end else begin
            hdr_acc = 1'b1;
            if (niu_sii_datareq) begin
              wr_cnt_d = sat_inc(wr_cnt_q);
              state_d  = ST_PAYLOAD;
              beat_d   = '0;
            end else begin
              rd_cnt_d = sat_inc(rd_cnt_q);
            end
          end
        end
      end else begin
        // A header during payload is dropped; the beat sequence keeps going.
        if (niu_sii_hdr_vld) begin
          err_det[ERR_HDR_IN_PAY] = 1'b1;
          err_det[ERR_DREQ16]     = niu_sii_datareq16;
        end
        if (beat_q == LAST_BEAT) begin
          state_d = ST_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BEAT_ONE;
        end
      end

      if (hdr_acc && niu_sii_reqbypass) byp_cnt_d = sat_inc(byp_cnt_q);
      oq_inc = hdr_acc && !niu_sii_reqbypass;
      oq_dec = sii_niu_oqdq;

      if (oq_inc && !oq_dec) begin
        if (occ_q == OQ_FULL) err_det[ERR_OQ_OVF] = 1'b1;
        else                  occ_d = occ_q + OCC_ONE;
      end else if (oq_dec && !oq_inc) begin
        if (occ_q == '0) err_det[ERR_OQ_UNF] = 1'b1;
        else             occ_d = occ_q - OCC_ONE;
      end

      err_det[ERR_PAR] = par_err;
    end

    // clr wins over same-cycle counter increments and error detections; FSM and occupancy still advance.
    if (clr) begin
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      byp_cnt_d = '0;
      err_d     = '0;
      pulse_d   = 1'b0;
    end else begin
      err_d   = err_q | err_det;
      pulse_d = |err_det;
    end
  end

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      byp_cnt_q <= '0;
      occ_q     <= '0;
      err_q     <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      byp_cnt_q <= byp_cnt_d;
      occ_q     <= occ_d;
      err_q     <= err_d;
      pulse_q   <= pulse_d;
    end
  end

  assign rd_cnt     = rd_cnt_q;
  assign wr_cnt     = wr_cnt_q;
  assign byp_cnt    = byp_cnt_q;
  assign oq_occ     = occ_q;
  assign err_sticky = err_q;
  assign err_pulse  = pulse_q;

endmodule

// File: tb/tb_niu_sii_inb_chk.sv
// Directed bench for niu_sii_inb_chk: a transaction-level model checked every cycle plus literal checkpoints.
// Inputs driven on the falling edge; DUT and model both advance on the rising edge.
module tb_niu_sii_inb_chk;

  localparam int DATA_W    = 64;
  localparam int PAY_BEATS = 4;
  localparam int OQ_DEPTH  = 16;
  localparam int CNT_W     = 4;
  localparam int PAR_W     = DATA_W / 16;
  localparam int OCC_W     = $clog2(OQ_DEPTH + 1);
  localparam int CMAX      = (1 << CNT_W) - 1;
`ifdef NIU_SII_INB_PARCHK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_l = 1'b0;
  logic              enable = 1'b0;
  logic              clr = 1'b0;
  logic              niu_sii_hdr_vld = 1'b0;
  logic              niu_sii_reqbypass = 1'b0;
  logic              niu_sii_datareq = 1'b0;
  logic              niu_sii_datareq16 = 1'b0;
  logic [DATA_W-1:0] niu_sii_data = '0;
  logic [PAR_W-1:0]  niu_sii_parity = '0;
  logic              sii_niu_oqdq = 1'b0;
  logic [CNT_W-1:0]  rd_cnt, wr_cnt, byp_cnt;
  logic [OCC_W-1:0]  oq_occ;
  logic [4:0]        err_sticky;
  logic              err_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  niu_sii_inb_chk #(
    .DATA_W(DATA_W), .PAY_BEATS(PAY_BEATS), .OQ_DEPTH(OQ_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .iol2clk(clk), .rst_l(rst_l), .enable(enable), .clr(clr),
    .niu_sii_hdr_vld(niu_sii_hdr_vld), .niu_sii_reqbypass(niu_sii_reqbypass),
    .niu_sii_datareq(niu_sii_datareq), .niu_sii_datareq16(niu_sii_datareq16),
    .niu_sii_data(niu_sii_data), .niu_sii_parity(niu_sii_parity),
    .sii_niu_oqdq(sii_niu_oqdq),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .byp_cnt(byp_cnt),
    .oq_occ(oq_occ), .err_sticky(err_sticky), .err_pulse(err_pulse)
  );

  function automatic logic [PAR_W-1:0] calc_par(input logic [DATA_W-1:0] d);
    logic [PAR_W-1:0] p;
    for (int i = 0; i < PAR_W; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: plain integer counters, "payload beats still owed" instead of an FSM.
  int         m_rd = 0, m_wr = 0, m_byp = 0, m_occ = 0, m_left = 0;
  logic [4:0] m_err = '0;
  logic       m_pulse = 1'b0;

  function automatic int sat(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_step();
    logic [4:0] det;
    bit inc_oq, dec_oq;
    det = '0; inc_oq = 0; dec_oq = 0;
    if (enable) begin
      if ((niu_sii_hdr_vld || m_left > 0) && (niu_sii_parity != calc_par(niu_sii_data)))
        det[0] = PAR_EN;
      if (m_left > 0) begin
        if (niu_sii_hdr_vld) det[1] = 1'b1;
        if (niu_sii_hdr_vld && niu_sii_datareq16) det[2] = 1'b1;
        m_left--;
      end else if (niu_sii_hdr_vld) begin
        if (niu_sii_datareq16) begin
          det[2] = 1'b1;
        end else begin
          if (niu_sii_datareq) begin
            m_wr   = sat(m_wr);
            m_left = PAY_BEATS;
          end else begin
            m_rd = sat(m_rd);
          end
          if (niu_sii_reqbypass) m_byp = sat(m_byp);
          else                   inc_oq = 1;
        end
      end
      dec_oq = sii_niu_oqdq;
      if (inc_oq && !dec_oq) begin
        if (m_occ == OQ_DEPTH) det[3] = 1'b1; else m_occ++;
      end else if (dec_oq && !inc_oq) begin
        if (m_occ == 0) det[4] = 1'b1; else m_occ--;
      end
    end
    if (clr) begin
      m_rd = 0; m_wr = 0; m_byp = 0; m_err = '0; m_pulse = 1'b0;
    end else begin
      m_err   = m_err | det;
      m_pulse = |det;
    end
  endtask

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_rd = 0; m_wr = 0; m_byp = 0; m_occ = 0; m_left = 0; m_err = '0; m_pulse = 1'b0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    chk("model rd_cnt",     int'(rd_cnt),     m_rd);
    chk("model wr_cnt",     int'(wr_cnt),     m_wr);
    chk("model byp_cnt",    int'(byp_cnt),    m_byp);
    chk("model oq_occ",     int'(oq_occ),     m_occ);
    chk("model err_sticky", int'(err_sticky), int'(m_err));
    chk("model err_pulse",  int'(err_pulse),  int'(m_pulse));
  end

  task automatic cyc(input bit h, input bit byp, input bit dr, input bit d16, input bit dq,
                     input bit flip3 = 1'b0);
    logic [DATA_W-1:0] d;
    logic [PAR_W-1:0]  m;
    d = {$urandom, $urandom};
    m = '0;
    m[3] = flip3;
    niu_sii_hdr_vld   = h;
    niu_sii_reqbypass = byp;
    niu_sii_datareq   = dr;
    niu_sii_datareq16 = d16;
    sii_niu_oqdq      = dq;
    niu_sii_data      = d;
    niu_sii_parity    = calc_par(d) ^ m;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset rd_cnt", int'(rd_cnt), 0);
    chk("reset oq_occ", int'(oq_occ), 0);
    chk("reset err_sticky", int'(err_sticky), 0);
    chk("reset err_pulse", int'(err_pulse), 0);
    rst_l = 1'b1;
    enable = 1'b1;

    // Ordered read then dequeue three cycles later.
    cyc(1, 0, 0, 0, 0);
    chk("read rd_cnt", int'(rd_cnt), 1);
    chk("read oq_occ", int'(oq_occ), 1);
    idle(2);
    cyc(0, 0, 0, 0, 1);
    chk("dequeue oq_occ", int'(oq_occ), 0);
    chk("read err_sticky", int'(err_sticky), 0);

    // Back-to-back bypass writes, then a read proves the FSM is back in IDLE.
    cyc(1, 1, 1, 0, 0); idle(4);
    cyc(1, 1, 1, 0, 0); idle(4);
    chk("b2b wr_cnt", int'(wr_cnt), 2);
    chk("b2b err_sticky", int'(err_sticky), 0);
    cyc(1, 1, 0, 0, 0);
    chk("after payload rd_cnt", int'(rd_cnt), 2);
    chk("after payload byp_cnt", int'(byp_cnt), 3);

    // Header on payload beat 2 is flagged and dropped.
    cyc(1, 1, 1, 0, 0); idle(2);
    cyc(1, 0, 0, 0, 0);
    chk("hdr-in-pay err_sticky", int'(err_sticky), 2);
    chk("hdr-in-pay err_pulse", int'(err_pulse), 1);
    chk("hdr-in-pay rd_cnt", int'(rd_cnt), 2);
    chk("hdr-in-pay oq_occ", int'(oq_occ), 0);
    idle(1);
    chk("pulse one cycle", int'(err_pulse), 0);
    chk("hdr-in-pay wr_cnt", int'(wr_cnt), 3);
    cyc(1, 1, 0, 0, 0);
    chk("idle after beat3 rd_cnt", int'(rd_cnt), 3);

    // datareq16 header: error only.
    cyc(1, 0, 0, 1, 0);
    chk("dreq16 err_sticky", int'(err_sticky), 6);
    chk("dreq16 rd_cnt", int'(rd_cnt), 3);

    // Disabled: header ignored.
    enable = 1'b0;
    cyc(1, 0, 0, 0, 0);
    chk("disabled rd_cnt", int'(rd_cnt), 3);
    chk("disabled err_pulse", int'(err_pulse), 0);
    enable = 1'b1;

    clr = 1'b1; idle(1); clr = 1'b0;
    chk("clr rd_cnt", int'(rd_cnt), 0);
    chk("clr wr_cnt", int'(wr_cnt), 0);
    chk("clr err_sticky", int'(err_sticky), 0);

    // Overflow, counter saturation, drain, underflow.
    for (int i = 0; i < 17; i++) cyc(1, 0, 0, 0, 0);
    chk("ovf oq_occ", int'(oq_occ), 16);
    chk("ovf err_sticky", int'(err_sticky), 8);
    chk("sat rd_cnt", int'(rd_cnt), 15);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0, 1);
    chk("drain oq_occ", int'(oq_occ), 0);
    cyc(0, 0, 0, 0, 1);
    chk("unf err_sticky", int'(err_sticky), 24);
    chk("unf oq_occ", int'(oq_occ), 0);
    cyc(1, 0, 0, 0, 1);
    chk("inc+deq at 0 oq_occ", int'(oq_occ), 0);
    chk("inc+deq at 0 err_pulse", int'(err_pulse), 0);

    // Parity flip on beat 1; a flip on an idle cycle is never checked.
    clr = 1'b1; idle(1); clr = 1'b0;
    cyc(0, 0, 0, 0, 0, 1'b1);
    chk("idle flip err_sticky", int'(err_sticky), 0);
    cyc(1, 1, 1, 0, 0); idle(1);
    cyc(0, 0, 0, 0, 0, 1'b1);
    idle(2);
    chk("parity err_sticky", int'(err_sticky), PAR_EN ? 1 : 0);

    // Reset mid-payload, clr while disabled, then a fresh header.
    clr = 1'b1; idle(1); clr = 1'b0;
    cyc(1, 1, 1, 0, 0); idle(1);
    #2 rst_l = 1'b0;
    enable = 1'b0;
    clr = 1'b1;
    idle(2);
    chk("rst wr_cnt", int'(wr_cnt), 0);
    chk("rst byp_cnt", int'(byp_cnt), 0);
    chk("rst oq_occ", int'(oq_occ), 0);
    chk("rst err_sticky", int'(err_sticky), 0);
    rst_l = 1'b1;
    idle(1);
    clr = 1'b0;
    enable = 1'b1;
    cyc(1, 0, 0, 0, 0);
    chk("post-rst rd_cnt", int'(rd_cnt), 1);
    chk("post-rst oq_occ", int'(oq_occ), 1);
    chk("post-rst err_sticky", int'(err_sticky), 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
